bcdsub4_seq: RTL and testbench

Sequential 4-digit packed-BCD subtractor: the inverse of the team's combinational 4-digit BCD adder. It computes D = A − B − bi one decimal digit per clock, least-significant digit first, and reports the borrow-out. The result is in ten's-complement form when the difference is negative. It sits beside the BCD adder and feeds the same per-digit seven-segment decoders, driven from a start/done handshake on the board clock.

---
 rtl/bcdsub4_seq_if.sv | 25 ++
 rtl/bcdsub4_seq.sv | 100 ++++++++++
 tb/tb_bcdsub4_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bcdsub4_seq_if.sv
// Start/done request bus for the sequential 4-digit BCD subtractor.
// The requester drives operands and start; the subtractor returns the result and status.
interface bcdsub4_seq_if;
    localparam int unsigned W = 16;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic         start;
    logic [W-1:0] d;
    logic         bo;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output a, b, bi, start,
        input  d, bo, busy, done, err
    );

    modport slave (
        input  a, b, bi, start,
        output d, bo, busy, done, err
    );
endinterface

// File: rtl/bcdsub4_seq.sv
// Sequential packed-BCD subtractor: D = A - B - bi, one digit per clock, LSD first.
// Negative differences come out in ten's complement with bo set.
module bcdsub4_seq (
    input  logic         hz100,
    input  logic         reset,
    bcdsub4_seq_if.slave bus
);
    localparam int unsigned DIGITS = 4;
    localparam int unsigned DW     = 4;
    localparam int unsigned W      = DIGITS * DW;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [1:0]    cnt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  d_q;
    logic          borrow;
    logic          bo_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [DW-1:0] a_dig_c;
    logic [DW-1:0] b_dig_c;
    logic [DW-1:0] d_dig_c;
    logic signed [5:0] t_c;
    logic          accept_c;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (v[i*DW +: DW] > 4'd9);
        end
        return bad;
    endfunction

    // Digit slice selected by cnt; out-of-range digits wrap to 4 bits like valid ones.
    always_comb begin
        a_dig_c  = a_q[{cnt, 2'b00} +: DW];
        b_dig_c  = b_q[{cnt, 2'b00} +: DW];
        t_c      = $signed({2'b00, a_dig_c}) - $signed({2'b00, b_dig_c})
                 - $signed({5'b00000, borrow});
        d_dig_c  = t_c[5] ? DW'(t_c + 6'sd10) : t_c[3:0];
        accept_c = bus.start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            borrow <= 1'b0;
            bo_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept_c) begin
            state  <= RUN;
            cnt    <= 2'd0;
            a_q    <= bus.a;
            b_q    <= bus.b;
            borrow <= bus.bi;
            d_q    <= '0;
            bo_q   <= 1'b0;
            err_q  <= has_bad_digit(bus.a) | has_bad_digit(bus.b);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    d_q[{cnt, 2'b00} +: DW] <= d_dig_c;
                    borrow <= t_c[5];
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        bo_q   <= t_c[5];
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d    = d_q;
    assign bus.bo   = bo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcdsub4_seq.sv
// Scoreboard bench for bcdsub4_seq: expected results queued at request, compared on done.
module tb_bcdsub4_seq;
    logic hz100 = 1'b0;
    logic reset;

    always #5 hz100 = ~hz100;

    bcdsub4_seq_if bus ();

    bcdsub4_seq dut (
        .hz100 (hz100),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        bo;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference: valid BCD operands only.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        exp_t e;
        int v;
        v = bcd2int(a) - bcd2int(b) - int'(bi);
        e.bo  = (v < 0);
        if (v < 0) v = v + 10000;
        e.d   = int2bcd(v);
        e.err = 1'b0;
        return e;
    endfunction

    always @(negedge hz100) begin
        if (!reset && bus.done === 1'b1) begin
            done_seen++;
            check("done_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("result_d", 32'(bus.d), 32'(mon_e.d));
                check("result_bo", 32'(bus.bo), 32'(mon_e.bo));
                check("result_err", 32'(bus.err), 32'(mon_e.err));
            end
        end
    end

    // One request; checks LSD-first digit fill, busy/done timing and hold. poke pulses start mid-RUN.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input exp_t e, input bit poke);
        logic [15:0] mask;
        @(negedge hz100);
        bus.a = a; bus.b = b; bus.bi = bi; bus.start = 1'b1;
        sb.push_back(e);
        @(negedge hz100);
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.bi = 1'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("d_cleared", 32'(bus.d), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge hz100);
            if (poke && k == 1) begin
                bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0000;
            end
            if (poke && k == 2) bus.start = 1'b0;
            mask = 16'hFFFF >> (16 - 4 * k);
            check("partial_d", 32'(bus.d), 32'(e.d & mask));
            if (k == 1) check("err_e1", 32'(bus.err), 32'(e.err));
            if (k < 4) begin
                check("busy_run", 32'(bus.busy), 32'd1);
                check("done_early", 32'(bus.done), 32'd0);
            end else begin
                check("done_e4", 32'(bus.done), 32'd1);
                check("busy_e4", 32'(bus.busy), 32'd0);
            end
        end
        @(negedge hz100);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("d_hold", 32'(bus.d), 32'(e.d));
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge hz100);
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n < 0) check("done_timeout", 32'(bus.done), 32'd1);
    endtask

    exp_t e_err;
    int   lat;
    int   done_before;
    logic [15:0] ra, rb;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
        repeat (2) @(negedge hz100);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_bo", 32'(bus.bo), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        @(negedge hz100);
        check("idle_busy", 32'(bus.busy), 32'd0);

        run_op(16'h3209, 16'h3333, 1'b0, model(16'h3209, 16'h3333, 1'b0), 1'b0);
        run_op(16'h1234, 16'h1111, 1'b0, model(16'h1234, 16'h1111, 1'b0), 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, model(16'h0000, 16'h0000, 1'b1), 1'b0);
        run_op(16'h9999, 16'h0000, 1'b0, model(16'h9999, 16'h0000, 1'b0), 1'b0);
        e_err = '{d: 16'h0099, bo: 1'b0, err: 1'b1};
        run_op(16'h00A0, 16'h0001, 1'b0, e_err, 1'b0);
        run_op(16'h0005, 16'h0003, 1'b0, model(16'h0005, 16'h0003, 1'b0), 1'b0);
        run_op(16'h5000, 16'h0001, 1'b1, model(16'h5000, 16'h0001, 1'b1), 1'b1);

        // start held high across three requests
        @(negedge hz100);
        bus.a = 16'h4321; bus.b = 16'h1234; bus.bi = 1'b0; bus.start = 1'b1;
        sb.push_back(model(16'h4321, 16'h1234, 1'b0));
        @(negedge hz100);
        bus.a = 16'h0100; bus.b = 16'h0200; bus.bi = 1'b1;
        sb.push_back(model(16'h0100, 16'h0200, 1'b1));
        wait_done(lat);
        check("b2b_latency0", 32'(lat), 32'd4);
        @(negedge hz100);
        check("b2b_reaccept_busy", 32'(bus.busy), 32'd1);
        check("b2b_reaccept_done", 32'(bus.done), 32'd0);
        bus.a = 16'h7777; bus.b = 16'h7777; bus.bi = 1'b0;
        sb.push_back(model(16'h7777, 16'h7777, 1'b0));
        wait_done(lat);
        check("b2b_period1", 32'(lat + 1), 32'd5);
        @(negedge hz100);
        bus.start = 1'b0;
        wait_done(lat);
        check("b2b_period2", 32'(lat + 1), 32'd5);
        @(negedge hz100);
        check("b2b_idle_done", 32'(bus.done), 32'd0);
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);

        // reset during RUN, right after the second digit edge
        @(negedge hz100);
        bus.a = 16'h00A0; bus.b = 16'h0001; bus.bi = 1'b0; bus.start = 1'b1;
        @(posedge hz100);
        @(negedge hz100);
        bus.start = 1'b0;
        @(posedge hz100);
        @(posedge hz100);
        #1;
        check("pre_rst_d", 32'(bus.d), 32'h0099);
        check("pre_rst_err", 32'(bus.err), 32'd1);
        done_before = done_seen;
        reset = 1'b1;
        #1;
        check("midrun_rst_d", 32'(bus.d), 32'd0);
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_err", 32'(bus.err), 32'd0);
        check("midrun_rst_bo", 32'(bus.bo), 32'd0);
        check("midrun_rst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge hz100);
        reset = 1'b0;
        repeat (8) @(negedge hz100);
        check("no_done_after_abort", 32'(done_seen), 32'(done_before));

        run_op(16'h2000, 16'h0999, 1'b0, model(16'h2000, 16'h0999, 1'b0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = int2bcd(int'($urandom_range(0, 9999)));
            rb = int2bcd(int'($urandom_range(0, 9999)));
            run_op(ra, rb, 1'(i), model(ra, rb, 1'(i)), 1'b0);
        end

        repeat (3) @(negedge hz100);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
